// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage holding the PC, driving the imem request/ready handshake,
// and applying stall and branch redirect. Optional `FETCH_STATS_EN adds fetch_count/wait_count.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        if_id_load,
  output logic        if_flush
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] wait_count
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  localparam logic [31:0] STEP = 32'(PC_STEP);

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] old_addr, old_addr_next;
  logic [31:0] hold_instr, hold_instr_next;
  logic [31:0] pc_out_next, instr_next;
  logic [31:0] pc_inc;
  logic        load_next;
  logic        started;
  logic        accept;

  // started keeps the request low until the first edge after reset releases.
  assign imem_req  = started && (state != HOLD);
  assign imem_addr = (state == DISCARD) ? old_addr : pc;
  assign accept    = imem_req && imem_ready;
  assign pc_inc    = pc + STEP;

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    old_addr_next   = old_addr;
    hold_instr_next = hold_instr;
    pc_out_next     = pc_out;
    instr_next      = instruction_out;
    load_next       = 1'b0;
    case (state)
      FETCH: begin
        if (pc_src) begin
          pc_next = branch_target;
          // An unanswered request must stay on the bus at its old address until ready.
          if (started && !imem_ready) begin
            old_addr_next = pc;
            state_next    = DISCARD;
          end
        end else if (accept) begin
          if (stall) begin
            hold_instr_next = imem_rdata;
            state_next      = HOLD;
          end else begin
            pc_out_next = pc;
            instr_next  = imem_rdata;
            load_next   = 1'b1;
            pc_next     = pc_inc;
          end
        end
      end
      HOLD: begin
        if (pc_src) begin
          pc_next    = branch_target;
          state_next = FETCH;
        end else if (!stall) begin
          pc_out_next = pc;
          instr_next  = hold_instr;
          load_next   = 1'b1;
          pc_next     = pc_inc;
          state_next  = FETCH;
        end
      end
      DISCARD: begin
        if (pc_src) pc_next = branch_target;
        if (imem_ready) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= FETCH;
      pc              <= RESET_PC;
      old_addr        <= 32'h0;
      hold_instr      <= 32'h0;
      pc_out          <= 32'h0;
      instruction_out <= 32'h0;
      if_id_load      <= 1'b0;
      if_flush        <= 1'b0;
      started         <= 1'b0;
    end else begin
      state           <= state_next;
      pc              <= pc_next;
      old_addr        <= old_addr_next;
      hold_instr      <= hold_instr_next;
      pc_out          <= pc_out_next;
      instruction_out <= instr_next;
      if_id_load      <= load_next;
      if_flush        <= pc_src;
      started         <= 1'b1;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_count <= 32'h0;
      wait_count  <= 32'h0;
    end else begin
      if (load_next) fetch_count <= fetch_count + 32'd1;
      if (imem_req && !imem_ready) wait_count <= wait_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scoreboard of expected {pc, instruction} deliveries
// plus directed per-scenario checks of request, address and flush behaviour.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        if_id_load;
  logic        if_flush;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] wait_count;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];

  localparam logic [31:0] PATTERN = 32'hA5A5_0000;

  fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .pc_src(pc_src),
    .branch_target(branch_target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .pc_out(pc_out),
    .instruction_out(instruction_out),
    .if_id_load(if_id_load),
    .if_flush(if_flush)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count(fetch_count),
    .wait_count(wait_count)
`endif
  );

  always #5 clock = ~clock;

  // Instruction memory: every word encodes its own address.
  assign imem_rdata = imem_addr ^ PATTERN;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, pc ^ PATTERN});
  endtask

  task automatic start_from_reset(input logic rdy);
    reset = 1'b0;
    stall = 1'b0;
    pc_src = 1'b0;
    branch_target = 32'h0;
    imem_ready = rdy;
    repeat (2) @(negedge clock);
    exp_q.delete();
    reset = 1'b1;
    tick();
  endtask

  task automatic drain_pipe;
    imem_ready = 1'b0;
    stall = 1'b0;
    pc_src = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    imem_ready = 1'b1;
    repeat (2) @(negedge clock);
    #3;
    n_checks++;
    if ({imem_req, pc_out, instruction_out, if_id_load, if_flush} !== 67'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got req=%0b pc_out=%h instr=%h load=%0b flush=%0b, required all zero",
               imem_req, pc_out, instruction_out, if_id_load, if_flush);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL req_before_edge: got %0b, required 0", imem_req);
    end
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL first_request: got req=%0b addr=%h, required req=1 addr=00000000", imem_req, imem_addr);
    end
    drain_pipe();
    exp_q.delete();
  endtask

  task automatic test_sequential;
    logic [31:0] exp_pc = 32'h0;
    start_from_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        n_fail++;
        $display("[TB] FAIL seq_addr: got req=%0b addr=%h, required req=1 addr=%h", imem_req, imem_addr, exp_pc);
      end
      if (i > 0) begin
        n_checks++;
        if (if_id_load !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL seq_load: got %0b, required 1", if_id_load);
        end
      end
      push_exp(exp_pc);
      tick();
      exp_pc = exp_pc + 32'd4;
    end
    drain_pipe();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL seq_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_wait_states;
    start_from_reset(1'b1);
    push_exp(32'h0);
    tick();
    push_exp(32'h4);
    tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_id_load !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL wait_hold: got req=%0b addr=%h load=%0b, required req=1 addr=00000008 load=0",
                 imem_req, imem_addr, if_id_load);
      end
    end
`ifdef FETCH_STATS_EN
    n_checks++;
    if (wait_count !== 32'd3) begin
      n_fail++;
      $display("[TB] FAIL wait_count: got %0d, required 3", wait_count);
    end
`endif
    imem_ready = 1'b1;
    push_exp(32'h8);
    tick();
    n_checks++;
    if (if_id_load !== 1'b1 || imem_addr !== 32'hC) begin
      n_fail++;
      $display("[TB] FAIL wait_resume: got load=%0b addr=%h, required load=1 addr=0000000c", if_id_load, imem_addr);
    end
    drain_pipe();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL wait_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_stall;
    start_from_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      push_exp(32'(i * 4));
      tick();
    end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (imem_req !== 1'b0 || if_id_load !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL stall_hold: got req=%0b load=%0b, required req=0 load=0", imem_req, if_id_load);
      end
    end
    stall = 1'b0;
    push_exp(32'h10);
    tick();
    n_checks++;
    if (if_id_load !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      n_fail++;
      $display("[TB] FAIL stall_release: got load=%0b req=%0b addr=%h, required load=1 req=1 addr=00000014",
               if_id_load, imem_req, imem_addr);
    end
    drain_pipe();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL stall_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_pending;
    start_from_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      push_exp(32'(i * 4));
      tick();
    end
    imem_ready = 1'b0;
    tick();
    pc_src = 1'b1;
    branch_target = 32'h100;
    tick();
    pc_src = 1'b0;
    n_checks++;
    if (if_flush !== 1'b1 || if_id_load !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      n_fail++;
      $display("[TB] FAIL discard_enter: got flush=%0b load=%0b req=%0b addr=%h, required flush=1 load=0 req=1 addr=00000020",
               if_flush, if_id_load, imem_req, imem_addr);
    end
    tick();
    n_checks++;
    if (if_flush !== 1'b0 || imem_addr !== 32'h20) begin
      n_fail++;
      $display("[TB] FAIL discard_wait: got flush=%0b addr=%h, required flush=0 addr=00000020", if_flush, imem_addr);
    end
    imem_ready = 1'b1;
    tick();
    n_checks++;
    if (if_id_load !== 1'b0 || imem_addr !== 32'h100) begin
      n_fail++;
      $display("[TB] FAIL discard_exit: got load=%0b addr=%h, required load=0 addr=00000100", if_id_load, imem_addr);
    end
    push_exp(32'h100);
    tick();
    n_checks++;
    if (if_id_load !== 1'b1 || imem_addr !== 32'h104) begin
      n_fail++;
      $display("[TB] FAIL target_fetch: got load=%0b addr=%h, required load=1 addr=00000104", if_id_load, imem_addr);
    end
    drain_pipe();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL redirect_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_ready_and_stall;
    start_from_reset(1'b1);
    push_exp(32'h0);
    tick();
    pc_src = 1'b1;
    branch_target = 32'h200;
    tick();
    pc_src = 1'b0;
    n_checks++;
    if (if_flush !== 1'b1 || if_id_load !== 1'b0 || imem_addr !== 32'h200) begin
      n_fail++;
      $display("[TB] FAIL redirect_ready: got flush=%0b load=%0b addr=%h, required flush=1 load=0 addr=00000200",
               if_flush, if_id_load, imem_addr);
    end
    push_exp(32'h200);
    tick();
    n_checks++;
    if (if_flush !== 1'b0 || if_id_load !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL flush_single: got flush=%0b load=%0b, required flush=0 load=1", if_flush, if_id_load);
    end
    stall = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b0 || if_id_load !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stall_enter: got req=%0b load=%0b, required req=0 load=0", imem_req, if_id_load);
    end
    pc_src = 1'b1;
    branch_target = 32'h300;
    tick();
    pc_src = 1'b0;
    stall = 1'b0;
    n_checks++;
    if (if_flush !== 1'b1 || if_id_load !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      n_fail++;
      $display("[TB] FAIL redirect_stall: got flush=%0b load=%0b req=%0b addr=%h, required flush=1 load=0 req=1 addr=00000300",
               if_flush, if_id_load, imem_req, imem_addr);
    end
    push_exp(32'h300);
    tick();
    n_checks++;
    if (if_flush !== 1'b0 || imem_addr !== 32'h304) begin
      n_fail++;
      $display("[TB] FAIL resume_target: got flush=%0b addr=%h, required flush=0 addr=00000304", if_flush, imem_addr);
    end
    drain_pipe();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL redirect2_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midrequest;
    start_from_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      push_exp(32'(i * 4));
      tick();
    end
    imem_ready = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      n_fail++;
      $display("[TB] FAIL pre_reset: got req=%0b addr=%h, required req=1 addr=0000000c", imem_req, imem_addr);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, pc_out, instruction_out, if_id_load, if_flush} !== 67'h0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got req=%0b pc_out=%h instr=%h load=%0b flush=%0b, required all zero",
               imem_req, pc_out, instruction_out, if_id_load, if_flush);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL restart: got req=%0b addr=%h, required req=1 addr=00000000", imem_req, imem_addr);
    end
    drain_pipe();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL restart_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_pc_wrap;
    logic [31:0] exp_pc = 32'hFFFF_FFF8;
    start_from_reset(1'b1);
    pc_src = 1'b1;
    branch_target = 32'hFFFF_FFF8;
    tick();
    pc_src = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (imem_addr !== exp_pc) begin
        n_fail++;
        $display("[TB] FAIL wrap_addr: got %h, required %h", imem_addr, exp_pc);
      end
      push_exp(exp_pc);
      tick();
      exp_pc = exp_pc + 32'd4;
    end
    n_checks++;
    if (imem_addr !== 32'h4) begin
      n_fail++;
      $display("[TB] FAIL wrap_next: got %h, required 00000004", imem_addr);
    end
    drain_pipe();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL wrap_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clock);
        if (reset) begin
          n_checks++;
          if (if_id_load === 1'b1 && if_flush === 1'b1) begin
            n_fail++;
            $display("[TB] FAIL load_flush_overlap: got load=1 flush=1, required never both");
          end
          if (if_id_load === 1'b1) begin
            logic [63:0] exp;
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("[TB] FAIL unexpected_load: got pc_out=%h instr=%h, required no load", pc_out, instruction_out);
            end else begin
              exp = exp_q.pop_front();
              if ({pc_out, instruction_out} !== exp) begin
                n_fail++;
                $display("[TB] FAIL delivery: got pc_out=%h instr=%h, required pc_out=%h instr=%h",
                         pc_out, instruction_out, exp[63:32], exp[31:0]);
              end
            end
          end
        end
      end
    join_none

    test_reset();
    test_sequential();
    test_wait_states();
    test_stall();
    test_redirect_pending();
    test_redirect_ready_and_stall();
    test_reset_midrequest();
    test_pc_wrap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. Holds the PC and drives a request/ready handshake to instruction memory. Presents each fetched {pc, instruction} pair with a one-cycle load strobe. Applies stall from the hazard unit and branch redirect from EX, and generates the IF/ID flush on a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low (0 = reset)
stall  input  1  hazard unit: hold PC, do not deliver to IF/ID
pc_src  input  1  branch/jump taken in EX, redirect fetch
branch_target  input  32  redirect address, valid when pc_src=1
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address; equals current PC
imem_ready  input  1  memory returns data this cycle
imem_rdata  input  32  instruction word, valid when imem_req && imem_ready
pc_out  output  32  PC of delivered instruction (to IF/ID pc_in)
instruction_out  output  32  delivered instruction (to IF/ID instruction_memory_in)
if_id_load  output  1  one-cycle strobe: IF/ID captures pc_out/instruction_out
if_flush  output  1  one-cycle strobe: IF/ID clears

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC, state=FETCH, imem_req=0, pc_out=0, instruction_out=0, if_id_load=0, if_flush=0. imem_req rises on the first rising edge after reset deasserts.
- Handshake: while imem_req=1, imem_addr is stable until a rising edge samples imem_ready=1. Zero wait states gives one instruction per cycle. imem_rdata is ignored when imem_ready=0.
- States:
  - FETCH: imem_req=1, addr=pc.
    - ready && !pc_src && !stall: register pc_out=pc and instruction_out=rdata, pulse if_id_load, pc += PC_STEP, stay in FETCH.
    - ready && stall && !pc_src: capture into hold buffer, go to HOLD, imem_req=0.
    - !ready && pc_src: go to DISCARD with pc=branch_target. The in-flight address is kept on imem_addr in a separate latched register until ready.
    - ready && pc_src: drop rdata, pc=branch_target, stay in FETCH.
  - HOLD: imem_req=0.
    - stall falls (pc_src=0): deliver the hold buffer with if_id_load, pc += PC_STEP, go to FETCH.
    - pc_src: drop the buffer, pc=branch_target, go to FETCH.
  - DISCARD: imem_req=1 on the old address. On ready, drop rdata and go to FETCH (new target issued next cycle). A further pc_src in DISCARD updates the target only.
- if_flush=1 for exactly the cycle after any pc_src sample (registered), in every state. if_id_load is never asserted in the same cycle as if_flush.
- Priority: reset > pc_src > stall > normal advance.
- pc_src is a single-cycle pulse; if it is held, every cycle is treated as a new redirect.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0. branch_target is taken unaligned, without check.
- Latency: rising edge with ready → if_id_load/pc_out/instruction_out valid after that edge, captured by IF/ID on the following negedge.
- Reset asserted mid-request: imem_req drops immediately (asynchronously). Any response is dropped.

Optional Feature:
FETCH_STATS_EN
- Defined: adds outputs fetch_count[31:0] (increments on each if_id_load) and wait_count[31:0] (increments each cycle imem_req=1 && imem_ready=0). Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
1. Reset release, RESET_PC=0, imem_ready tied 1, rdata=addr^32'hA5A5_0000 → addr 0,4,8,… on consecutive cycles; if_id_load every cycle; pc_out 0,4,8 matches instruction_out.
2. imem_ready low for 3 cycles at addr 8 → imem_addr held at 8 for 4 cycles, no if_id_load until ready; with FETCH_STATS_EN, wait_count=3.
3. stall high 2 cycles when ready returns at addr 0x10 → no load while stalled, imem_req=0; on stall low, pc_out=0x10 delivered once, next addr 0x14.
4. pc_src=1, target 0x100, while addr 0x20 pending (ready low) → if_flush pulse next cycle; 0x20 data dropped on ready; next request addr 0x100, first load pc_out=0x100.
5. pc_src with ready in same cycle, and pc_src during stall → no load of dropped word, if_flush one cycle, fetch resumes at target.
6. reset pulled low mid-request at addr 0xC, and PC at 0xFFFF_FFFC → imem_req=0 and outputs zero immediately, restart at RESET_PC; separately, PC wraps 0xFFFF_FFFC→0x0000_0000.
